// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, skid state encoding and ID/EX control bundle layout for pipeline stages.
package pipe_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_t;
  localparam int CTRL_LOAD      = 0;
  localparam int CTRL_STORE     = 1;
  localparam int CTRL_JALR      = 2;
  localparam int CTRL_REG_WRITE = 3;
  localparam int CTRL_ALU_LSB   = 4;
  localparam int CTRL_ALU_W     = 4;
  localparam int CTRL_IDEX_W    = 16;
  typedef struct packed {
    logic [3:0] rsvd;
    logic [1:0] wb_sel;
    logic       branch;
    logic       mem_to_reg;
    logic [3:0] alu_control;
    logic       reg_write;
    logic       jalr;
    logic       store;
    logic       load;
  } idex_ctrl_t;
endpackage

// File: rtl/pipe_skid_ctl.sv
// pipe_skid_ctl: occupancy FSM for the 2-entry skid stage; produces registered in_ready and entry enables.
module pipe_skid_ctl import pipe_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic       load_main,
  output logic       load_skid,
  output logic       move_skid,
  output logic       clear_main,
  output logic [1:0] occupancy
);
  state_t state, state_n;
  logic accept, drain;
  assign out_valid = state != ST_EMPTY;
  assign occupancy = state;
  assign accept = in_valid & in_ready;
  assign drain = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= state_n != ST_FULL;
    end
  // clear_main loads the bubble whenever main goes empty
  always_comb begin
    state_n    = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    clear_main = 1'b0;
    if (flush) begin
      state_n    = ST_EMPTY;
      clear_main = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          state_n   = ST_ONE;
          load_main = 1'b1;
        end
        ST_ONE: if (accept && drain) load_main = 1'b1;
        else if (accept) begin
          state_n   = ST_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_n    = ST_EMPTY;
          clear_main = 1'b1;
        end
        ST_FULL: if (drain) begin
          state_n   = ST_ONE;
          move_skid = 1'b1;
        end
        default: begin
          state_n    = ST_EMPTY;
          clear_main = 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer and flush bubble.
// Optional PIPE_STAGE_PERF_EN adds stall_cnt/bubble_cnt performance counters.
module pipe_stage_skid import pipe_pkg::*; #(
  parameter int CTRL_W  = 16,
  parameter int DATA_W  = 133,
  parameter int INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [INSTR_W-1:0] out_instr,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt,
`endif
  output logic [1:0]         occupancy
);
  logic load_main, load_skid, move_skid, clear_main;
  logic [CTRL_W-1:0]  skid_ctrl;
  logic [DATA_W-1:0]  skid_data;
  logic [INSTR_W-1:0] skid_instr;
  pipe_skid_ctl u_ctl (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .load_main  (load_main),
    .load_skid  (load_skid),
    .move_skid  (move_skid),
    .clear_main (clear_main),
    .occupancy  (occupancy)
  );
  // reset leaves out_instr at 0, only a bubble load drives the NOP
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_ctrl  <= '0;
      out_data  <= '0;
      out_instr <= '0;
    end else if (clear_main) begin
      out_ctrl  <= '0;
      out_data  <= '0;
      out_instr <= NOP_INSTR;
    end else if (load_main) begin
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
      out_instr <= in_instr;
    end else if (move_skid) begin
      out_ctrl  <= skid_ctrl;
      out_data  <= skid_data;
      out_instr <= skid_instr;
    end
  always_ff @(posedge clk)
    if (load_skid) begin
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
      skid_instr <= in_instr;
    end
`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      stall_cnt  <= stall_cnt + 32'(out_valid & ~out_ready);
      bubble_cnt <= bubble_cnt + 32'(~out_valid & out_ready);
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: table-driven check of pipe_stage_skid plus async-reset and perf-counter sequences.
module tb_pipe_stage_skid;
  localparam int CW = 16;
  localparam int DW = 133;
  localparam int IW = 32;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic [IW-1:0] in_instr = '0;
  logic in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_instr;
  logic [1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;

  pipe_stage_skid dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_instr (out_instr),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
`endif
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        iv;
    logic [31:0] instr;
    logic        ordy;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [1:0]  e_occ;
    logic        e_rdy;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [CW-1:0] ctrl_of(input logic [31:0] i);
    return i[15:0] ^ 16'hA5C3;
  endfunction
  function automatic logic [DW-1:0] data_of(input logic [31:0] i);
    return {i, ~i, i, ~i, i[4:0]};
  endfunction

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic f, input logic iv, input logic [31:0] ins, input logic ordy,
                     input logic ev, input logic [31:0] ei, input logic [1:0] eo, input logic er);
    vec_t v;
    v.flush = f; v.iv = iv; v.instr = ins; v.ordy = ordy;
    v.e_valid = ev; v.e_instr = ei; v.e_occ = eo; v.e_rdy = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic f, input logic iv, input logic [31:0] ins, input logic ordy);
    flush = f;
    in_valid = iv;
    in_instr = iv ? ins : '0;
    in_ctrl = iv ? ctrl_of(ins) : '0;
    in_data = iv ? data_of(ins) : '0;
    out_ready = ordy;
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [31:0] ei,
                           input logic [1:0] eo, input logic er);
    chk({tag, " out_valid"}, 136'(out_valid), 136'(ev));
    chk({tag, " out_instr"}, 136'(out_instr), 136'(ei));
    chk({tag, " out_ctrl"}, 136'(out_ctrl), ev ? 136'(ctrl_of(ei)) : 136'(0));
    chk({tag, " out_data"}, 136'(out_data), ev ? 136'(data_of(ei)) : 136'(0));
    chk({tag, " occupancy"}, 136'(occupancy), 136'(eo));
    chk({tag, " in_ready"}, 136'(in_ready), 136'(er));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) add(0, 1, 32'h100 + i, 1, 1, 32'h100 + i, 1, 1);
    add(0, 0, 0, 1, 0, NOP, 0, 1);
    add(0, 1, 32'hA1, 0, 1, 32'hA1, 1, 1);
    add(0, 1, 32'hA2, 0, 1, 32'hA1, 2, 0);
    add(0, 1, 32'hA3, 0, 1, 32'hA1, 2, 0);
    add(0, 1, 32'hA3, 1, 1, 32'hA2, 1, 1);
    add(0, 1, 32'hA3, 1, 1, 32'hA3, 1, 1);
    add(0, 0, 0, 1, 0, NOP, 0, 1);
    add(0, 1, 32'hC1, 0, 1, 32'hC1, 1, 1);
    add(0, 1, 32'hC2, 0, 1, 32'hC1, 2, 0);
    add(1, 1, 32'hB0, 0, 0, NOP, 0, 1);
    add(0, 0, 0, 1, 0, NOP, 0, 1);
    add(0, 1, 32'hD1, 0, 1, 32'hD1, 1, 1);
    add(1, 1, 32'hB1, 1, 0, NOP, 0, 1);
    add(0, 0, 0, 1, 0, NOP, 0, 1);
    add(1, 1, 32'hB2, 1, 0, NOP, 0, 1);
    add(1, 1, 32'hB3, 1, 0, NOP, 0, 1);
    add(0, 1, 32'hE1, 0, 1, 32'hE1, 1, 1);
    add(0, 0, 0, 1, 0, NOP, 0, 1);
    add(0, 1, 32'hF1, 0, 1, 32'hF1, 1, 1);
    add(0, 1, 32'hF2, 0, 1, 32'hF1, 2, 0);
    add(0, 0, 0, 1, 1, 32'hF2, 1, 1);
    add(0, 0, 0, 1, 0, NOP, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk_state("reset held", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk_state("after release", 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flush, vecs[i].iv, vecs[i].instr, vecs[i].ordy);
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_occ, vecs[i].e_rdy);
    end

    drive(0, 1, 32'hC5, 0);
    @(posedge clk);
    #1;
    drive(0, 1, 32'hC6, 0);
    @(posedge clk);
    #1;
    chk_state("pre async rst", 1, 32'hC5, 2, 0);
    #2 rst = 1'b0;
    #1;
    chk_state("async rst", 0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk_state("async release", 0, 0, 0, 1);

`ifdef PIPE_STAGE_PERF_EN
    begin
      logic [31:0] s0, b0;
      drive(0, 1, 32'h77, 0);
      @(posedge clk);
      #1;
      s0 = stall_cnt;
      b0 = bubble_cnt;
      drive(0, 0, 0, 0);
      repeat (5) @(posedge clk);
      #1;
      drive(0, 0, 0, 1);
      repeat (4) @(posedge clk);
      #1;
      chk("stall_cnt delta", 136'(stall_cnt - s0), 136'(5));
      chk("bubble_cnt delta", 136'(bubble_cnt - b0), 136'(3));
      s0 = stall_cnt;
      b0 = bubble_cnt;
      drive(1, 0, 0, 0);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0);
      chk("stall_cnt flush", 136'(stall_cnt), 136'(s0));
      chk("bubble_cnt flush", 136'(bubble_cnt), 136'(b0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
